// File: rtl/bram_stream_fifo.sv
// bram_stream_fifo: first-word-fall-through valid/ready FIFO built on an
// external simple dual-port block RAM with one-cycle registered read.
// A three-entry output buffer absorbs the RAM read latency, so the FIFO
// sustains one word per cycle in both directions.
module bram_stream_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Pointers carry a wrap bit so full and empty RAM are distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   ram_occ;
    logic [1:0]            pending;
    logic [1:0]            out_cnt;
    logic [1:0]            cap_idx;
    logic [2:0]            slots_used;
    logic [DATA_WIDTH-1:0] out_buf0;
    logic [DATA_WIDTH-1:0] out_buf1;
    logic [DATA_WIDTH-1:0] out_buf2;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;
    logic                  capture;

    assign s_ready     = !rst && (count != FULL_COUNT);
    assign push        = s_valid && s_ready;
    assign m_valid     = (out_cnt != 2'd0);
    assign m_data      = out_buf0;
    assign pop         = m_valid && m_ready;

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = s_data;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // Words written to RAM but not yet read out of it.
    assign ram_occ     = wr_ptr - rd_ptr;

    // A read issued last cycle has its data on ram_rd_data now.
    assign capture     = (pending != 2'd0);

    // Buffer slots that will be spoken for after this cycle's pop, counting
    // reads still in flight; a new read is issued only if one slot remains.
    assign slots_used  = {1'b0, out_cnt} + {1'b0, pending} - {2'b00, pop};
    assign rd_issue    = (ram_occ != '0) && (slots_used < 3'd3);

    // Captured word lands just behind whatever survives this cycle's pop.
    assign cap_idx     = out_cnt - {1'b0, pop};

    // Pointer, in-flight read and buffer occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
            out_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            pending <= pending + {1'b0, rd_issue} - {1'b0, capture};
            out_cnt <= out_cnt + {1'b0, capture} - {1'b0, pop};
        end
    end

    // Output buffer: shift toward the head on pop, then drop in captured RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_buf0 <= '0;
            out_buf1 <= '0;
            out_buf2 <= '0;
        end else begin
            if (pop) begin
                out_buf0 <= out_buf1;
                out_buf1 <= out_buf2;
            end
            if (capture) begin
                case (cap_idx)
                    2'd0:    out_buf0 <= ram_rd_data;
                    2'd1:    out_buf1 <= ram_rd_data;
                    default: out_buf2 <= ram_rd_data;
                endcase
            end
        end
    end

    // Total words held: moves only on push or pop, never on internal transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Testbench for bram_stream_fifo: models the block RAM, drives directed and
// random traffic, and compares every cycle against a queue-based reference.
module tb_bram_stream_fifo;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW:0]   count;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    bram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM with registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference: words in order with the cycle they were accepted.
    logic [DW-1:0] ref_data [$];
    int            ref_cyc  [$];
    int            wr_cnt   = 0;
    int            cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic r, input logic sv, input logic [DW-1:0] sd,
                        input logic mr, output logic pushed);
        logic exp_sr, exp_mv, exp_push;
        rst = r; s_valid = sv; s_data = sd; m_ready = mr;
        @(negedge clk);
        exp_sr = !r && (ref_data.size() != DEPTH);
        exp_mv = 1'b0;
        if (ref_data.size() > 0) begin
            // A word becomes visible three cycles after its push, never earlier.
            if (cyc - ref_cyc[0] >= 3) exp_mv = 1'b1;
        end
        exp_push = sv && exp_sr;
        chk("s_ready", s_ready, exp_sr);
        chk("m_valid", m_valid, exp_mv);
        chk("count", count, ref_data.size());
        if (exp_mv) chk("m_data", m_data, ref_data[0]);
        chk("wr_en", ram_wr_en, exp_push);
        if (exp_push) begin
            chk("wr_addr", ram_wr_addr, wr_cnt % DEPTH);
            chk("wr_data", ram_wr_data, sd);
        end
        @(posedge clk);
        if (r) begin
            ref_data.delete();
            ref_cyc.delete();
            wr_cnt = 0;
        end else begin
            if (exp_mv && mr) begin
                void'(ref_data.pop_front());
                void'(ref_cyc.pop_front());
            end
            if (exp_push) begin
                ref_data.push_back(sd);
                ref_cyc.push_back(cyc);
                wr_cnt++;
            end
        end
        cyc++;
        pushed = exp_push;
        #1;
    endtask

    initial begin
        logic p;
        int   n;
        logic mr;

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 1'b1, 8'h11, 1'b1, p);
        chk("rst_mdata", m_data, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0, p);

        // Fill to full with consumer stalled, one rejected push, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0, p);
        step(1'b0, 1'b1, 8'hEE, 1'b0, p);
        chk("full_reject", p, 0);
        chk("full_count", count, DEPTH);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 8'h00, 1'b1, p);
        chk("drained_count", count, 0);

        // Continuous streaming, 64 words
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, DW'(i), 1'b1, p);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, p);

        // Consumer toggling while 30 words are pushed
        n = 0; mr = 1'b1;
        for (int i = 0; i < 100 && n < 30; i++) begin
            step(1'b0, 1'b1, DW'(8'h40 + n), mr, p);
            if (p) n++;
            mr = !mr;
        end
        chk("toggle_pushed", n, 30);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 8'h00, mr, p);
            mr = !mr;
        end
        chk("toggle_empty", count, 0);

        // Full FIFO: push 0xAA while popping; refused first, accepted next
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(8'h80 + i), 1'b0, p);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, p);
        n = -1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'hAA, 1'b1, p);
            if (p) begin
                n = i;
                break;
            end
        end
        chk("aa_accept_cycle", n, 1);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 8'h00, 1'b1, p);

        // Reset while reads are in flight, then 0x5A must be the first word out
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(8'hC0 + i), 1'b0, p);
        step(1'b1, 1'b0, 8'h00, 1'b0, p);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_mvalid", m_valid, 0);
        step(1'b0, 1'b1, 8'h5A, 1'b1, p);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, p);

        // Single word into an empty FIFO from address 0
        step(1'b1, 1'b0, 8'h00, 1'b0, p);
        step(1'b0, 1'b1, 8'h33, 1'b1, p);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, p);

        // Random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 DW'($urandom),
                 (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 p);
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 8'h00, 1'b1, p);
        chk("final_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
